// File: rtl/balance_pkg.sv
// Shared constants for the balance PID controller:
// mode encodings, FSM state type and term-enable helpers.
package balance_pkg;

  localparam logic [1:0] MODE_P   = 2'b00;
  localparam logic [1:0] MODE_PD  = 2'b01;
  localparam logic [1:0] MODE_PI  = 2'b10;
  localparam logic [1:0] MODE_PID = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ERR  = 2'd1,
    S_MUL  = 2'd2,
    S_OUT  = 2'd3
  } state_t;

  function automatic logic use_i(input logic [1:0] m);
    return (m == MODE_PI) || (m == MODE_PID);
  endfunction

  function automatic logic use_d(input logic [1:0] m);
    return (m == MODE_PD) || (m == MODE_PID);
  endfunction

endpackage

// File: rtl/pid_sat.sv
// Signed saturator: clamps din to [MINV, MAXV] and narrows it.
// Ports: din (IN_W signed), dout (OUT_W signed), clip (limit hit).
module pid_sat #(
  parameter int     IN_W  = 17,
  parameter int     OUT_W = 16,
  parameter longint MAXV  = (longint'(1) <<< (OUT_W - 1)) - 1,
  parameter longint MINV  = -MAXV - 1
) (
  input  logic signed [IN_W-1:0]  din,
  output logic signed [OUT_W-1:0] dout,
  output logic                    clip
);

  localparam logic signed [IN_W-1:0] HI = IN_W'(MAXV);
  localparam logic signed [IN_W-1:0] LO = IN_W'(MINV);

  always_comb begin
    dout = din[OUT_W-1:0];
    clip = 1'b0;
    if (din > HI) begin
      dout = HI[OUT_W-1:0];
      clip = 1'b1;
    end else if (din < LO) begin
      dout = LO[OUT_W-1:0];
      clip = 1'b1;
    end
  end

endmodule

// File: rtl/balance_pid_ctrl.sv
// Four-state PID controller: error/integrator, products+sum, output.
// Ports: clk, rst, in_valid, sensor, setpoint, kp, ki, kd, mode,
// int_clr in; pwm, out_valid, sat_flag, busy out.
module balance_pid_ctrl
  import balance_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int COEF_W  = 16,
  parameter int FRAC    = 8,
  parameter int OUT_W   = 16,
  parameter int INT_LIM = 2**(DATA_W+2) - 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] sensor,
  input  logic [DATA_W-1:0] setpoint,
  input  logic [COEF_W-1:0] kp,
  input  logic [COEF_W-1:0] ki,
  input  logic [COEF_W-1:0] kd,
  input  logic [1:0]        mode,
  input  logic              int_clr,
  output logic [OUT_W-1:0]  pwm,
  output logic              out_valid,
  output logic              sat_flag,
  output logic              busy
);

  localparam int E_W  = DATA_W + 1;
  localparam int D_W  = DATA_W + 2;
  localparam int I_W  = DATA_W + 3;
  localparam int PP_W = COEF_W + E_W;
  localparam int PI_W = COEF_W + I_W;
  localparam int PD_W = COEF_W + D_W;
  localparam int S_W  = PI_W + 2;

  state_t state, state_nxt;

  logic [DATA_W-1:0]        sens_q, setp_q;
  logic signed [COEF_W-1:0] kp_q, ki_q, kd_q;
  logic [1:0]               mode_q;
  logic signed [E_W-1:0]    err_q, last_err;
  logic signed [D_W-1:0]    derr_q;
  logic signed [I_W-1:0]    integ;
  logic                     first;

  logic signed [E_W-1:0]    err_c;
  logic signed [D_W-1:0]    derr_c;
  logic signed [I_W:0]      integ_sum;
  logic signed [I_W-1:0]    integ_sat, integ_nxt;
  logic                     integ_clip;

  logic signed [PP_W-1:0]   p_c;
  logic signed [PI_W-1:0]   i_c;
  logic signed [PD_W-1:0]   d_c;
  logic signed [S_W-1:0]    sum_c, sum_sh;
  logic signed [OUT_W-1:0]  pwm_c;
  logic                     sat_c;

  // FSM
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: if (in_valid) state_nxt = S_ERR;
      S_ERR:  state_nxt = S_MUL;
      S_MUL:  state_nxt = S_OUT;
      S_OUT:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign busy = (state != S_IDLE);

  // error stage
  always_comb begin
    err_c = $signed({1'b0, sens_q}) - $signed({1'b0, setp_q});
    derr_c = '0;
    if (!first)
      derr_c = $signed({err_c[E_W-1], err_c})
             - $signed({last_err[E_W-1], last_err});
    integ_sum = $signed({integ[I_W-1], integ})
              + $signed({{3{err_c[E_W-1]}}, err_c});
  end

  pid_sat #(
    .IN_W (I_W + 1),
    .OUT_W(I_W),
    .MAXV (longint'(INT_LIM)),
    .MINV (-longint'(INT_LIM))
  ) u_int_sat (
    .din (integ_sum),
    .dout(integ_sat),
    .clip(integ_clip)
  );

  assign integ_nxt = integ_clip ? integ_sat
                                : integ_sum[I_W-1:0];

  // product/sum stage; result lands in pwm as OUT is entered,
  // so out_valid and the new pwm appear in the same cycle
  always_comb begin
    p_c = PP_W'(kp_q) * PP_W'(err_q);
    i_c = '0;
    d_c = '0;
    if (use_i(mode_q)) i_c = PI_W'(ki_q) * PI_W'(integ);
    if (use_d(mode_q)) d_c = PD_W'(kd_q) * PD_W'(derr_q);
    sum_c  = S_W'(p_c) + S_W'(i_c) + S_W'(d_c);
    sum_sh = sum_c >>> FRAC;
  end

  pid_sat #(
    .IN_W (S_W),
    .OUT_W(OUT_W)
  ) u_out_sat (
    .din (sum_sh),
    .dout(pwm_c),
    .clip(sat_c)
  );

  // datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      sens_q    <= '0;
      setp_q    <= '0;
      kp_q      <= '0;
      ki_q      <= '0;
      kd_q      <= '0;
      mode_q    <= MODE_P;
      err_q     <= '0;
      derr_q    <= '0;
      last_err  <= '0;
      integ     <= '0;
      first     <= 1'b1;
      pwm       <= '0;
      out_valid <= 1'b0;
      sat_flag  <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (state == S_IDLE && in_valid) begin
        sens_q <= sensor;
        setp_q <= setpoint;
        kp_q   <= $signed(kp);
        ki_q   <= $signed(ki);
        kd_q   <= $signed(kd);
        mode_q <= mode;
      end
      if (state == S_ERR) begin
        err_q    <= err_c;
        derr_q   <= derr_c;
        last_err <= err_c;
        first    <= 1'b0;
        if (use_i(mode_q)) integ <= integ_nxt;
      end
      if (state == S_MUL) begin
        pwm       <= pwm_c;
        sat_flag  <= sat_c;
        out_valid <= 1'b1;
      end
      // clear overrides any same-cycle history update
      if (int_clr) begin
        integ    <= '0;
        last_err <= '0;
        first    <= 1'b1;
      end
    end
  end

endmodule
